// File: rtl/ifetch_queue.sv
// Instruction fetch unit: a sequential fetch PC drives a combinational ROM.
// Fetched {pc, instr} pairs go into a 2-entry queue that decode drains.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [1:0]  fifo_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_instr_q [2];

    logic pop;
    logic push;
    logic tail;
    logic unused_redirect_lsbs;

    // Fetch addresses are word aligned, so the redirect byte offset is dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop  = (count_q != 2'd0) & id_ready;
    assign push = (state_q == ST_RUN) & ~halt & ~redirect_valid
                & ((count_q != 2'd2) | pop);
    // Tail slot is head + count modulo 2; with count=2 that is the slot being freed by pop.
    assign tail = head_q ^ count_q[0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        count_d = count_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
            count_d = 2'd0;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (halt) state_d = ST_HALT;
                default: state_d = state_q;
            endcase
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ent_pc_q[gi]    <= 32'd0;
                    ent_instr_q[gi] <= 32'd0;
                end else if (push && (tail == 1'(gi))) begin
                    ent_pc_q[gi]    <= pc_q;
                    ent_instr_q[gi] <= rom_instr;
                end
            end
        end
    endgenerate

    assign rom_addr   = pc_q;
    assign id_valid   = (count_q != 2'd0);
    assign id_pc      = ent_pc_q[head_q];
    assign id_instr   = ent_instr_q[head_q];
    assign fifo_count = count_q;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port rom_addr  output  32  byte address to the instruction ROM (ROM indexes by addr[31:2]).
REQ-005 SHALL have port rom_instr  input  32  instruction word returned combinationally by the ROM for rom_addr.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port halt  input  1  stop issuing fetches.
REQ-009 SHALL have port id_valid  output  1  queue head holds a valid instruction for decode.
REQ-010 SHALL have port id_ready  input  1  decode accepts the head this cycle.
REQ-011 SHALL have port id_pc  output  32  byte address of the head instruction.
REQ-012 SHALL have port id_instr  output  32  head instruction word.
REQ-013 SHALL have port fifo_count  output  2  queue occupancy, 0..2.

Function
REQ-014 SHALL hold the fetch PC in a register; rom_addr SHALL equal that register combinationally; PC[1:0] SHALL always be 2'b00.
REQ-015 SHALL buffer {pc, instr} pairs in a 2-entry FIFO; id_valid = (fifo_count != 0); id_pc/id_instr = head entry.
REQ-016 SHALL implement states BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT when halt=1 and redirect_valid=0; HALT->RUN only on redirect_valid=1; any state->RUN on redirect_valid=1.
REQ-017 SHALL define pop = id_valid & id_ready; head advances, count decrements on pop.
REQ-018 SHALL define push = (state==RUN) & ~halt & ~redirect_valid & (fifo_count<2 | pop); on push, {pc, rom_instr} written at tail and pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 SHALL allow simultaneous push and pop at any occupancy, including full (count stays 2) and one (count stays 1, head becomes the new entry).
REQ-020 SHALL give redirect_valid highest priority after reset: next cycle count=0, id_valid=0, pc={redirect_pc[31:2],2'b00}, no push that cycle; a concurrent pop is discarded with the flush.
REQ-021 SHALL not push in the cycle halt is sampled 1 in RUN; in HALT the FIFO SHALL keep draining via pop.
REQ-022 SHALL keep id_pc/id_instr stable while id_valid=1 and id_ready=0.
REQ-023 SHALL give fetch-to-decode latency of one cycle: an entry pushed at edge N is visible on id_* after edge N when it becomes head.
REQ-024 SHALL ignore id_ready when id_valid=0 (no count underflow).

Reset
REQ-025 SHALL, on rising edge with rst_n=0, set pc=RESET_PC, state=BOOT, fifo_count=0, id_valid=0, both FIFO entries (and so id_pc, id_instr) to 0, irrespective of other inputs, including mid-operation.
REQ-026 SHALL issue no push in the first cycle after rst_n rises (BOOT); first push occurs in the second cycle; id_valid=1 with id_pc=RESET_PC in the third.

Verification
REQ-027 SHALL test: reset release, id_ready=1, ROM = 32'h00500293, 32'h00300313, ... -> id_valid rises cycle 3, id_pc 0,4,8,... one per cycle, id_instr matching ROM words.
REQ-028 SHALL test: id_ready=0 from cycle 3 for 5 cycles -> fifo_count reaches 2, rom_addr holds at 8, id_pc stays 0; raise id_ready -> id_pc 0,4,8 with no gap or duplicate.
REQ-029 SHALL test: redirect_valid=1, redirect_pc=32'h0000_0043 with count=2 -> next cycle count=0, id_valid=0, rom_addr=32'h40; cycle after, id_pc=32'h40.
REQ-030 SHALL test: halt=1 with count=1, id_ready=1 -> no further pushes, FIFO drains to 0, state HALT; redirect to 32'h10 -> fetching resumes at 32'h10.
REQ-031 SHALL test: redirect to 32'hFFFF_FFFC, id_ready=1 -> successive id_pc 32'hFFFF_FFFC, 32'h0000_0000.
REQ-032 SHALL test: rst_n=0 for one cycle while count=2 and redirect_valid=1 -> all outputs at reset values, rom_addr=RESET_PC, BOOT sequence repeats.
